// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared definitions for the pixel-clock video blocks:
//                pattern mode encodings, the colour-bar table as {r,g,b}
//                on/off flags, and the 640x480 default timing constants
//                shared with dvi_tx_parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Pattern selection.
    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECK    = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    // 640x480 @ 60 Hz timing, shared with the DVI transmitter.
    localparam int c_def_h_active = 640;
    localparam int c_def_h_front  = 16;
    localparam int c_def_h_sync   = 96;
    localparam int c_def_h_back   = 48;
    localparam int c_def_h_total  = 800;
    localparam int c_def_v_active = 480;
    localparam int c_def_v_front  = 10;
    localparam int c_def_v_sync   = 2;
    localparam int c_def_v_back   = 33;
    localparam int c_def_v_total  = 525;

    // Colour-bar table, left to right. Each flag is expanded to a full
    // channel by replication, so the table is independent of colour depth.
    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        logic [2:0] flags;
        case (idx)
            3'd0:    flags = 3'b111;  // white
            3'd1:    flags = 3'b110;  // yellow
            3'd2:    flags = 3'b011;  // cyan
            3'd3:    flags = 3'b010;  // green
            3'd4:    flags = 3'b101;  // magenta
            3'd5:    flags = 3'b100;  // red
            3'd6:    flags = 3'b001;  // blue
            default: flags = 3'b000;  // black
        endcase
        return flags;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_raster_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : video_raster_ctr
//  Description : Raster position counters (x, y, frame) with sof/eol flags.
//                Besides the registered position it exposes the next-state
//                values so that downstream pixel logic can register a colour
//                for the new position in the same cycle the position moves.
//  Ports       : clk, rst          - pixel clock, sync active-high reset
//                i_adv             - advance one pixel this cycle
//                o_x/o_y/o_frame   - current position and completed frames
//                o_sof/o_eol       - current pixel is (0,0) / last in line
//                o_*_nxt           - values the registers take at the edge
//  Revision    : 1.0 - initial release
// ============================================================================
module video_raster_ctr #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FRAME_W  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_adv,
    output logic [10:0]        o_x,
    output logic [10:0]        o_y,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_sof,
    output logic               o_eol,
    output logic [10:0]        o_x_nxt,
    output logic [10:0]        o_y_nxt,
    output logic [FRAME_W-1:0] o_frame_nxt,
    output logic               o_sof_nxt
);

    localparam logic [10:0] c_x_last = 11'(H_ACTIVE - 1);
    localparam logic [10:0] c_y_last = 11'(V_ACTIVE - 1);

    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic [FRAME_W-1:0] r_frame;
    logic               r_sof;
    logic               r_eol;

    logic [10:0]        w_x_nxt;
    logic [10:0]        w_y_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic               w_sof_nxt;
    logic               w_eol_nxt;

    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_frame_nxt = r_frame;
        if (i_adv) begin
            if (r_x == c_x_last) begin
                w_x_nxt = '0;
                if (r_y == c_y_last) begin
                    w_y_nxt     = '0;
                    // Free-running: wraps modulo 2^FRAME_W.
                    w_frame_nxt = r_frame + 1'b1;
                end else begin
                    w_y_nxt = r_y + 11'd1;
                end
            end else begin
                w_x_nxt = r_x + 11'd1;
            end
        end
    end

    assign w_sof_nxt = (w_x_nxt == 11'd0) && (w_y_nxt == 11'd0);
    assign w_eol_nxt = (w_x_nxt == c_x_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
            r_sof   <= 1'b1;
            r_eol   <= 1'b0;
        end else begin
            // Next-state equals current state when not advancing.
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_frame <= w_frame_nxt;
            r_sof   <= w_sof_nxt;
            r_eol   <= w_eol_nxt;
        end
    end

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_frame     = r_frame;
    assign o_sof       = r_sof;
    assign o_eol       = r_eol;
    assign o_x_nxt     = w_x_nxt;
    assign o_y_nxt     = w_y_nxt;
    assign o_frame_nxt = w_frame_nxt;
    assign o_sof_nxt   = w_sof_nxt;

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern_gen
//  Description : Raster-ordered RGB test-pattern source for dvi_tx_parallel.
//                The consumer pulls pixels with rgb_rdy (qualified by en).
//                Patterns: gradient, colour bars, checkerboard, solid. The
//                pattern mode is latched only when the raster returns to
//                (0,0), so a frame is never torn by a mode change.
//  Ports       : clk, rst          - pixel clock, sync active-high reset
//                en, rgb_rdy       - advance when both high
//                mode, solid_rgb   - pattern select, {r,g,b} for solid mode
//                r, g, b           - registered colour of current pixel
//                x, y, frame       - current position, completed frames
//                sof, eol          - current pixel is (0,0) / end of line
//  Options     : VIDEO_PATTERN_GEN_BORDER_EN - force a one-pixel white
//                border around the active area in modes 0-2.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = c_def_h_active,
    parameter int V_ACTIVE   = c_def_v_active,
    parameter int CW         = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int FRAME_W    = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [3*CW-1:0]    solid_rgb,
    input  logic               rgb_rdy,
    output logic [CW-1:0]      r,
    output logic [CW-1:0]      g,
    output logic [CW-1:0]      b,
    output logic [10:0]        x,
    output logic [10:0]        y,
    output logic               sof,
    output logic               eol,
    output logic [FRAME_W-1:0] frame
);

    localparam int          c_gw     = CW - 2;
    localparam logic [10:0] c_bw_m1  = 11'(H_ACTIVE / 8 - 1);
`ifdef VIDEO_PATTERN_GEN_BORDER_EN
    localparam logic [10:0] c_x_last = 11'(H_ACTIVE - 1);
    localparam logic [10:0] c_y_last = 11'(V_ACTIVE - 1);
`endif

    logic               w_adv;
    logic [10:0]        w_x_nxt;
    logic [10:0]        w_y_nxt;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic               w_sof_nxt;

    assign w_adv = rgb_rdy & en;

    video_raster_ctr #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .FRAME_W  (FRAME_W)
    ) u_raster (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (w_adv),
        .o_x         (x),
        .o_y         (y),
        .o_frame     (frame),
        .o_sof       (sof),
        .o_eol       (eol),
        .o_x_nxt     (w_x_nxt),
        .o_y_nxt     (w_y_nxt),
        .o_frame_nxt (w_frame_nxt),
        .o_sof_nxt   (w_sof_nxt)
    );

    // ------------------------------------------------------------------
    // Active mode: takes the mode input only when advancing onto (0,0).
    // ------------------------------------------------------------------
    mode_e r_mode;
    mode_e w_mode_nxt;

    assign w_mode_nxt = (w_adv && w_sof_nxt) ? mode_e'(mode) : r_mode;

    // ------------------------------------------------------------------
    // Colour-bar tracking. r_bar_cnt counts pixels inside the current bar;
    // the index saturates at 7 so the H_ACTIVE%8 remainder joins bar 7.
    // ------------------------------------------------------------------
    logic [10:0] r_bar_cnt;
    logic [2:0]  r_bar_idx;
    logic [10:0] w_bar_cnt_nxt;
    logic [2:0]  w_bar_idx_nxt;

    always_comb begin
        w_bar_cnt_nxt = r_bar_cnt;
        w_bar_idx_nxt = r_bar_idx;
        if (w_adv) begin
            if (eol) begin
                w_bar_cnt_nxt = '0;
                w_bar_idx_nxt = '0;
            end else if (r_bar_cnt == c_bw_m1) begin
                w_bar_cnt_nxt = '0;
                if (r_bar_idx != 3'd7) begin
                    w_bar_idx_nxt = r_bar_idx + 3'd1;
                end
            end else begin
                w_bar_cnt_nxt = r_bar_cnt + 11'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Colour for the next-state position and mode.
    // ------------------------------------------------------------------
    logic [c_gw-1:0] w_r_sum;
    logic [c_gw-1:0] w_g_sum;
    logic [2:0]      w_flags;
    logic            w_chk;
    logic [CW-1:0]   w_r_col;
    logic [CW-1:0]   w_g_col;
    logic [CW-1:0]   w_b_col;

    // The <<2 of the gradient drops the top two bits, so the sums only
    // need CW-2 bits.
    assign w_r_sum = c_gw'(w_x_nxt) + c_gw'(w_frame_nxt);
    assign w_g_sum = c_gw'(w_y_nxt) + c_gw'(w_frame_nxt);
    assign w_flags = bar_flags(w_bar_idx_nxt);
    assign w_chk   = w_x_nxt[CHECK_LOG2] ^ w_y_nxt[CHECK_LOG2] ^ w_frame_nxt[0];

`ifdef VIDEO_PATTERN_GEN_BORDER_EN
    logic w_border;
    assign w_border = (w_x_nxt == 11'd0) || (w_x_nxt == c_x_last) ||
                      (w_y_nxt == 11'd0) || (w_y_nxt == c_y_last);
`endif

    always_comb begin
        w_r_col = '0;
        w_g_col = '0;
        w_b_col = '0;
        case (w_mode_nxt)
            MODE_GRADIENT: begin
                w_r_col = {w_r_sum, 2'b00};
                w_g_col = {w_g_sum, 2'b00};
                w_b_col = CW'(w_frame_nxt);
            end
            MODE_BARS: begin
                w_r_col = {CW{w_flags[2]}};
                w_g_col = {CW{w_flags[1]}};
                w_b_col = {CW{w_flags[0]}};
            end
            MODE_CHECK: begin
                w_r_col = {CW{w_chk}};
                w_g_col = {CW{w_chk}};
                w_b_col = {CW{w_chk}};
            end
            MODE_SOLID: begin
                w_r_col = solid_rgb[3*CW-1:2*CW];
                w_g_col = solid_rgb[2*CW-1:CW];
                w_b_col = solid_rgb[CW-1:0];
            end
            default: begin
                w_r_col = '0;
            end
        endcase
`ifdef VIDEO_PATTERN_GEN_BORDER_EN
        if ((w_mode_nxt != MODE_SOLID) && w_border) begin
            w_r_col = '1;
            w_g_col = '1;
            w_b_col = '1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registered outputs and state.
    // ------------------------------------------------------------------
    logic [CW-1:0] r_r;
    logic [CW-1:0] r_g;
    logic [CW-1:0] r_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= MODE_GRADIENT;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_bar_cnt <= w_bar_cnt_nxt;
            r_bar_idx <= w_bar_idx_nxt;
            if (w_adv) begin
                r_r <= w_r_col;
                r_g <= w_g_col;
                r_b <= w_b_col;
            end
        end
    end

    assign r = r_r;
    assign g = r_g;
    assign b = r_b;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_pattern_gen
//  Description : Self-checking bench for video_pattern_gen. A pixel-index
//                model derives position and colour for every cycle; literal
//                expectations pin specific pixels of each pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pattern_gen;

    localparam int H   = 67;   // BW = 8, bar 7 spans x = 56..66
    localparam int V   = 10;
    localparam int CW  = 8;
    localparam int CL  = 2;
    localparam int FW  = 3;
    localparam int BW  = H / 8;
    localparam int FP  = H * V;

    localparam logic [23:0] c_bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
        24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [23:0]   solid_rgb;
    logic          rgb_rdy;
    logic [CW-1:0] r, g, b;
    logic [10:0]   x, y;
    logic          sof, eol;
    logic [FW-1:0] frame;

    always #5 clk = ~clk;

    video_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CW(CW), .CHECK_LOG2(CL), .FRAME_W(FW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .rgb_rdy(rgb_rdy), .r(r), .g(g), .b(b), .x(x), .y(y),
        .sof(sof), .eol(eol), .frame(frame)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- model: pixel index since reset ----------------
    int          m_n    = 0;
    int          m_mode = 0;
    logic [23:0] m_rgb  = '0;
    bit          chk_on = 1'b0;

    function automatic int mx(int n); return n % H; endfunction
    function automatic int my(int n); return (n / H) % V; endfunction
    function automatic int mf(int n); return (n / FP) % (1 << FW); endfunction

    function automatic logic [23:0] model_rgb(int px, int py, int pf, int md,
                                              logic [23:0] s);
        int bar;
        case (md)
            0: return {8'((px + pf) * 4), 8'((py + pf) * 4), 8'(pf)};
            1: begin
                bar = px / BW;
                if (bar > 7) bar = 7;
                return c_bars[bar];
            end
            2: return ((((px >> CL) & 1) ^ ((py >> CL) & 1) ^ (pf & 1)) != 0)
                      ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int nn;
        int md;
        if (rst) begin
            m_n    <= 0;
            m_mode <= 0;
            m_rgb  <= '0;
        end else if (rgb_rdy && en) begin
            nn = m_n + 1;
            md = (mx(nn) == 0 && my(nn) == 0) ? int'(mode) : m_mode;
            m_n    <= nn;
            m_mode <= md;
            m_rgb  <= model_rgb(mx(nn), my(nn), mf(nn), md, solid_rgb);
        end
    end

    // ---------------- per-cycle stream compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            n_checks++;
            if (x !== 11'(mx(m_n)) || y !== 11'(my(m_n)) ||
                frame !== FW'(mf(m_n)) ||
                sof !== (mx(m_n) == 0 && my(m_n) == 0) ||
                eol !== (mx(m_n) == H - 1) || {r, g, b} !== m_rgb) begin
                n_errors++;
                $display("FAIL stream n=%0d got x=%0d y=%0d f=%0d sof=%b eol=%b rgb=%h want x=%0d y=%0d f=%0d sof=%b eol=%b rgb=%h",
                         m_n, x, y, frame, sof, eol, {r, g, b},
                         mx(m_n), my(m_n), mf(m_n), (mx(m_n) == 0 && my(m_n) == 0),
                         (mx(m_n) == H - 1), m_rgb);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(string nm, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_rgb(string nm, logic [23:0] want);
        check({"rgb ", nm}, 64'({r, g, b}), 64'(want));
        check({"model ", nm}, 64'(m_rgb), 64'(want));
    endtask

    task automatic run_to(int tx, int ty, int tf);
        int k = 0;
        rgb_rdy = 1'b1;
        en      = 1'b1;
        while (!(mx(m_n) == tx && my(m_n) == ty && mf(m_n) == tf) && k < 10000) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 10000) begin
            n_errors++;
            $display("FAIL run_to (%0d,%0d,%0d) got timeout want reached", tx, ty, tf);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b1; rgb_rdy = 1'b0; mode = 2'd0; solid_rgb = '0;
        @(negedge clk);
        repeat (3) tick();
        check("reset_pos", 64'({x, y, frame, sof, eol}), 64'({11'd0, 11'd0, 3'd0, 1'b1, 1'b0}));
        check("reset_rgb", 64'({r, g, b}), 64'd0);
        rst    = 1'b0;
        chk_on = 1'b1;

        // Holding without rdy, then en low with rdy high.
        repeat (3) tick();
        rgb_rdy = 1'b1; en = 1'b0;
        repeat (3) tick();

        // Gradient, frame 0.
        run_to(3, 2, 0);
        check_rgb("grad_3_2", 24'h0C0800);
        run_to(10, 5, 0);
        mode = 2'd1;
        run_to(20, 5, 0);
        check_rgb("grad_after_modechg", 24'h501400);

        // Colour bars, frame 1.
        run_to(7, 0, 1);
        check_rgb("bar_x7", 24'hFFFFFF);
        run_to(8, 0, 1);
        check_rgb("bar_x8", 24'hFFFF00);
        run_to(55, 0, 1);
        check_rgb("bar_x55", 24'h0000FF);
        run_to(56, 0, 1);
        check_rgb("bar_x56", 24'h000000);
        run_to(66, 0, 1);
        check_rgb("bar_x66", 24'h000000);
        check("eol_x66", 64'(eol), 64'd1);

        // Throttled pull with an en-low window.
        for (int i = 0; i < 90; i++) begin
            rgb_rdy = (i % 3 == 0);
            en      = !(i >= 45 && i < 60);
            tick();
        end

        // Checkerboard, frames 2 and 3.
        mode = 2'd2;
        run_to(3, 0, 2);
        check_rgb("chk_f2_3_0", 24'h000000);
        run_to(4, 0, 2);
        check_rgb("chk_f2_4_0", 24'hFFFFFF);
        run_to(4, 4, 2);
        check_rgb("chk_f2_4_4", 24'h000000);
        run_to(3, 0, 3);
        check_rgb("chk_f3_3_0", 24'hFFFFFF);
        run_to(4, 0, 3);
        check_rgb("chk_f3_4_0", 24'h000000);

        // Solid, frame 4; solid_rgb is not frame-latched.
        mode = 2'd3; solid_rgb = 24'h123456;
        run_to(0, 1, 4);
        check_rgb("solid_123456", 24'h123456);
        solid_rgb = 24'hABCDEF;
        tick();
        check_rgb("solid_abcdef", 24'hABCDEF);

        // Frame counter wrap 7 -> 0.
        run_to(0, 0, 7);
        check("frame7", 64'(frame), 64'd7);
        run_to(0, 0, 0);
        check("frame_wrap", 64'(frame), 64'd0);

        // Reset mid-frame together with rdy.
        run_to(30, 4, 0);
        rst = 1'b1; rgb_rdy = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_pos", 64'({x, y, frame, sof, eol}), 64'({11'd0, 11'd0, 3'd0, 1'b1, 1'b0}));
        check("rst_mid_rgb", 64'({r, g, b}), 64'd0);

        // Random pull pattern after reset.
        for (int i = 0; i < 300; i++) begin
            rgb_rdy = 1'($urandom_range(0, 1));
            tick();
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
